// File: rtl/instram_loader_arb.sv
// rtl/instram_loader_arb.sv - instruction RAM port arbiter between CPU fetch and byte-serial loader
// Optional feature: define INSTRAM_LOAD_CHECKSUM_EN to add the ld_sum session checksum output.
`timescale 1ns/1ps
module instram_loader_arb #(
    parameter int LOAD_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cpu_addr,
    output logic [15:0] cpu_inst,
    output logic        cpu_stall,
    input  logic        ld_start,
    input  logic [7:0]  ld_byte,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        ld_done,
    output logic [7:0]  ram_add,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout
`ifdef INSTRAM_LOAD_CHECKSUM_EN
    ,
    output logic [15:0] ld_sum
`endif
);

    localparam logic [7:0] LAST_PTR = 8'(LOAD_WORDS - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BYTE_HI = 2'd1,
        BYTE_LO = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  ptr;
    logic [15:0] word;
    logic        done_q;

    logic accept;
    logic start_ok;
    logic last_wr;

    assign accept   = ld_valid & ld_ready;
    assign start_ok = (state == RUN) & ld_start;
    assign last_wr  = (state == WR) && (ptr == LAST_PTR);

    assign ld_done  = done_q;
    assign ram_din  = word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Word pointer, byte assembly and end-of-session pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 8'h00;
            word   <= 16'h0000;
            done_q <= 1'b0;
        end else begin
            if (start_ok) begin
                ptr <= 8'h00;
            end else if (state == WR) begin
                ptr <= ptr + 8'h01;
            end
            if (accept && (state == BYTE_HI)) begin
                word[15:8] <= ld_byte;
            end
            if (accept && (state == BYTE_LO)) begin
                word[7:0] <= ld_byte;
            end
            done_q <= last_wr;
        end
    end

`ifdef INSTRAM_LOAD_CHECKSUM_EN
    // Running sum of every word written in the current session
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_sum <= 16'h0000;
        end else if (start_ok) begin
            ld_sum <= 16'h0000;
        end else if (state == WR) begin
            ld_sum <= ld_sum + word;
        end
    end
`endif

    // Next state and RAM port / CPU-side outputs
    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_add   = ptr;
        cpu_stall = 1'b1;
        cpu_inst  = 16'h0000;
        case (state)
            RUN: begin
                ram_add   = cpu_addr;
                cpu_inst  = ram_dout;
                cpu_stall = 1'b0;
                if (ld_start) begin
                    state_nxt = BYTE_HI;
                end
            end
            BYTE_HI: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    state_nxt = BYTE_LO;
                end
            end
            BYTE_LO: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    state_nxt = WR;
                end
            end
            WR: begin
                ram_we    = 1'b1;
                state_nxt = last_wr ? RUN : BYTE_HI;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_instram_loader_arb.sv
// tb/tb_instram_loader_arb.sv - self-checking bench for instram_loader_arb
`timescale 1ns/1ps
module tb_instram_loader_arb;

    localparam int N0 = 2;
    localparam int N1 = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cpu_addr [2];
    logic [15:0] cpu_inst [2];
    logic        cpu_stall[2];
    logic        st       [2];
    logic [7:0]  lb       [2];
    logic        val      [2];
    logic        rdy      [2];
    logic        done     [2];
    logic [7:0]  add      [2];
    logic [15:0] din      [2];
    logic        we       [2];
    logic [15:0] dout     [2];
`ifdef INSTRAM_LOAD_CHECKSUM_EN
    logic [15:0] sum      [2];
`endif

    always #5 clk = ~clk;

    instram_loader_arb #(.LOAD_WORDS(N0)) u0 (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr[0]), .cpu_inst(cpu_inst[0]),
        .cpu_stall(cpu_stall[0]), .ld_start(st[0]), .ld_byte(lb[0]), .ld_valid(val[0]),
        .ld_ready(rdy[0]), .ld_done(done[0]), .ram_add(add[0]), .ram_din(din[0]),
        .ram_we(we[0]), .ram_dout(dout[0])
`ifdef INSTRAM_LOAD_CHECKSUM_EN
        , .ld_sum(sum[0])
`endif
    );

    instram_loader_arb #(.LOAD_WORDS(N1)) u1 (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr[1]), .cpu_inst(cpu_inst[1]),
        .cpu_stall(cpu_stall[1]), .ld_start(st[1]), .ld_byte(lb[1]), .ld_valid(val[1]),
        .ld_ready(rdy[1]), .ld_done(done[1]), .ram_add(add[1]), .ram_din(din[1]),
        .ram_we(we[1]), .ram_dout(dout[1])
`ifdef INSTRAM_LOAD_CHECKSUM_EN
        , .ld_sum(sum[1])
`endif
    );

    // Instruction RAMs: synchronous write, asynchronous read; bench preload port on RAM 0
    logic [15:0] mem0[256];
    logic [15:0] mem1[256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [15:0] pre_val = 16'h0000;
    assign dout[0] = mem0[add[0]];
    assign dout[1] = mem1[add[1]];

    always @(posedge clk) begin
        if (we[0]) mem0[add[0]] <= din[0];
        else if (pre_we) mem0[pre_addr] <= pre_val;
        if (we[1]) mem1[add[1]] <= din[1];
    end

    // Write log {dut, addr, data} and ld_done pulse counts
    logic [24:0] qlog[$];
    int          dcnt[2] = '{0, 0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n === 1'b1 && we[d] === 1'b1) qlog.push_back({1'(d), add[d], din[d]});
            if (rst_n === 1'b1 && done[d] === 1'b1) dcnt[d]++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // While stalled the CPU must see a NOP
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n === 1'b1 && cpu_stall[d] === 1'b1) chk("nop_during_stall", 32'(cpu_inst[d]), 32'h0);
        end
    end

    // Reference image of RAM 0 as the bench expects it
    logic [15:0] img[256];
    logic [7:0]  pat[$];

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] val;
        logic [15:0] exp_inst;
        logic        exp_stall;
        logic        exp_we;
    } vec_t;
    vec_t tv[6];

    task automatic do_start(input int d);
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        chk("stall_after_start", 32'(cpu_stall[d]), 32'h1);
        chk("ready_after_start", 32'(rdy[d]), 32'h1);
    endtask

    task automatic send(input int d, input logic [7:0] b, input int gap, input bit stray);
        bit ok = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        lb[d] = b; val[d] = 1'b1; st[d] = stray;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy[d]) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        val[d] = 1'b0; st[d] = 1'b0;
        chk("byte_accepted", 32'(ok), 32'h1);
    endtask

    // Feeds one session's bytes into an already-started DUT and checks the outcome against the model
    task automatic feed(input int d, input int n, input int gmin, input int gmax, input bit stray, input bit restart);
        logic [7:0]  bq[$];
        logic [15:0] w[$];
        logic [15:0] msum = 16'h0;
        int          base, d0, k;
        bit          ok = 1'b0;
        if (pat.size() > 0) begin bq = pat; pat.delete(); end
        else for (int i = 0; i < 2 * n; i++) bq.push_back(8'($urandom));
        for (int i = 0; i < n; i++) begin
            w.push_back({bq[2 * i], bq[2 * i + 1]});
            msum = msum + w[i];
        end
        base = qlog.size();
        d0   = dcnt[d];
        for (int i = 0; i < 2 * n; i++)
            send(d, bq[i], int'($urandom_range(gmax, gmin)), stray && ($urandom_range(3, 0) == 0));
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done[d]) begin ok = 1'b1; break; end
        end
        chk("done_seen", 32'(ok), 32'h1);
        chk("stall_low_at_done", 32'(cpu_stall[d]), 32'h0);
`ifdef INSTRAM_LOAD_CHECKSUM_EN
        chk("ld_sum_session", 32'(sum[d]), 32'(msum));
`endif
        if (restart) st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        chk("done_one_cycle", 32'(done[d]), 32'h0);
        if (restart) begin
            chk("restart_on_done", 32'(cpu_stall[d]), 32'h1);
`ifdef INSTRAM_LOAD_CHECKSUM_EN
            chk("ld_sum_cleared", 32'(sum[d]), 32'h0);
`endif
        end
        k = 0;
        for (int j = base; j < qlog.size(); j++) begin
            if (qlog[j][24] == 1'(d)) begin
                if (k < n) begin
                    chk("write_addr", 32'(qlog[j][23:16]), 32'(k % 256));
                    chk("write_data", 32'(qlog[j][15:0]), 32'(w[k]));
                    if (d == 0) img[k % 256] = w[k];
                end
                k++;
            end
        end
        chk("write_count", 32'(k), 32'(n));
        chk("done_pulses", 32'(dcnt[d] - d0), 32'h1);
    endtask

    task automatic rand_reads();
        logic [7:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            cpu_addr[0] = a; #1;
            chk("run_fetch", 32'(cpu_inst[0]), 32'(img[a]));
            chk("run_no_stall", 32'(cpu_stall[0]), 32'h0);
        end
    endtask

    initial begin
        int base;
        for (int d = 0; d < 2; d++) begin
            cpu_addr[d] = 8'h00; st[d] = 1'b0; lb[d] = 8'h00; val[d] = 1'b0;
        end
        tv[0] = '{8'h05, 16'hA1B2, 16'hA1B2, 1'b0, 1'b0};
        tv[1] = '{8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tv[2] = '{8'hFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        tv[3] = '{8'h80, 16'h8001, 16'h8001, 1'b0, 1'b0};
        tv[4] = '{8'h2A, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0};
        tv[5] = '{8'h06, 16'h1357, 16'h1357, 1'b0, 1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_stall", 32'(cpu_stall[d]), 32'h0);
            chk("reset_ready", 32'(rdy[d]), 32'h0);
            chk("reset_we", 32'(we[d]), 32'h0);
            chk("reset_done", 32'(done[d]), 32'h0);
`ifdef INSTRAM_LOAD_CHECKSUM_EN
            chk("reset_sum", 32'(sum[d]), 32'h0);
`endif
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Preload RAM 0 with random contents, then the table entries
        pre_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_addr = 8'(i); pre_val = 16'($urandom); img[i] = pre_val;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 6; i++) begin
            pre_addr = tv[i].addr; pre_val = tv[i].val; img[tv[i].addr] = tv[i].val;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;

        // Zero-latency fetch: address changes without any clock edge in between
        for (int i = 0; i < 6; i++) begin
            cpu_addr[0] = tv[i].addr; #1;
            chk("tbl_inst", 32'(cpu_inst[0]), 32'(tv[i].exp_inst));
            chk("tbl_stall", 32'(cpu_stall[0]), 32'(tv[i].exp_stall));
            chk("tbl_we", 32'(we[0]), 32'(tv[i].exp_we));
        end

        // Continuous bytes, then 3-cycle gaps
        pat = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_start(0); feed(0, N0, 0, 0, 1'b0, 1'b0);
        pat = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_start(0); feed(0, N0, 3, 3, 1'b0, 1'b0);
        rand_reads();

        // Reset after the first byte
        do_start(0);
        send(0, 8'hAB, 0, 1'b0);
        rst_n = 1'b0; #1;
        chk("midreset_stall", 32'(cpu_stall[0]), 32'h0);
        chk("midreset_ready", 32'(rdy[0]), 32'h0);
        chk("midreset_we", 32'(we[0]), 32'h0);
        base = qlog.size();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("no_write_after_reset", 32'(qlog.size()), 32'(base));
`ifdef INSTRAM_LOAD_CHECKSUM_EN
        chk("midreset_sum", 32'(sum[0]), 32'h0);
`endif
        do_start(0); feed(0, N0, 0, 2, 1'b0, 1'b0);

        // Checksum wrap, restart on the ld_done cycle, then finish the new session
        pat = '{8'hFF, 8'hFF, 8'h00, 8'h02};
        do_start(0); feed(0, N0, 0, 1, 1'b0, 1'b1);
        feed(0, N0, 0, 1, 1'b0, 1'b0);

        // Randomized sessions with stray ld_start pulses
        for (int s = 0; s < 20; s++) begin
            do_start(0); feed(0, N0, 0, 3, 1'b1, 1'b0);
            rand_reads();
        end

        // Full 256-word session
        do_start(1); feed(1, N1, 0, 1, 1'b1, 1'b0);
        chk("full_no_stall_after", 32'(cpu_stall[1]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instram_loader_arb.md
INSTRAM_LOADER_ARB -- requirements
Module: instram_loader_arb

Interface
REQ-001 SHALL have parameter LOAD_WORDS, default 256, meaning number of 16-bit words written per load session (legal 1..256).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cpu_addr  input  8  CPU fetch address.
REQ-005 SHALL have port cpu_inst  output  16  fetched instruction to CPU.
REQ-006 SHALL have port cpu_stall  output  1  CPU must hold PC while high.
REQ-007 SHALL have port ld_start  input  1  single-cycle request to begin a load session.
REQ-008 SHALL have port ld_byte  input  8  loader data byte.
REQ-009 SHALL have port ld_valid  input  1  ld_byte valid.
REQ-010 SHALL have port ld_ready  output  1  block accepts ld_byte this cycle.
REQ-011 SHALL have port ld_done  output  1  one-cycle pulse at session end.
REQ-012 SHALL have ports ram_add  output  8, ram_din  output  16, ram_we  output  1, ram_dout  input  16, driving the single-port instruction RAM (write on clock edge, asynchronous read).

Function
REQ-013 SHALL implement FSM states RUN, BYTE_HI, BYTE_LO, WR; reset state RUN.
REQ-014 In RUN: ram_add = cpu_addr, ram_we = 0, cpu_inst = ram_dout combinationally (zero-cycle fetch latency), cpu_stall = 0, ld_ready = 0.
REQ-015 RUN with ld_start = 1 SHALL clear word pointer ptr to 0 and go to BYTE_HI next cycle.
REQ-016 In BYTE_HI: ld_ready = 1; byte accepted only when ld_valid & ld_ready; accepted byte stored as word[15:8]; go to BYTE_LO.
REQ-017 In BYTE_LO: ld_ready = 1; accepted byte stored as word[7:0]; go to WR.
REQ-018 In WR: ld_ready = 0, ram_we = 1 for exactly one cycle, ram_add = ptr, ram_din = assembled word; ptr increments by 1 (8-bit, wraps 255->0).
REQ-019 From WR: if ptr == LOAD_WORDS-1 go to RUN and assert ld_done for exactly the first RUN cycle; else go to BYTE_HI.
REQ-020 In BYTE_HI, BYTE_LO, WR: ram_add = ptr, cpu_stall = 1, cpu_inst = 16'h0000 (NOP); ram_we = 0 outside WR.
REQ-021 ld_start outside RUN SHALL be ignored; ld_start and ld_done coincident in same cycle SHALL start a new session.
REQ-022 ld_valid while ld_ready = 0 SHALL be ignored, byte dropped, no state change.
REQ-023 ram_din SHALL hold last assembled word when ram_we = 0.

Reset
REQ-024 rst_n low SHALL immediately force: state RUN, ptr 0, assembled word 0, ld_done 0, ld_ready 0, ram_we 0, cpu_stall 0.
REQ-025 Reset mid-session SHALL abandon the session with no further RAM write; words already written remain in RAM.

Configuration
REQ-026 With macro INSTRAM_LOAD_CHECKSUM_EN defined SHALL add port ld_sum  output  16  modulo-2^16 sum of all words written this session, cleared on accepted ld_start and on reset, updated in the cycle after each WR.
REQ-027 Without INSTRAM_LOAD_CHECKSUM_EN, port ld_sum and its adder SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset then cpu_addr=8'h05 with ram_dout=16'hA1B2 -> cpu_inst=16'hA1B2 same cycle, cpu_stall=0, ram_we=0.
REQ-029 LOAD_WORDS=2, ld_start, bytes 12,34,56,78 with ld_valid continuous -> writes 16'h1234 @0 then 16'h5678 @1, one ram_we cycle each, ld_done single pulse, cpu_stall=1 from cycle after ld_start until ld_done cycle.
REQ-030 ld_valid gaps of 3 cycles between bytes -> same writes/addresses as REQ-029, cpu_inst=0 throughout stall.
REQ-031 rst_n low after first byte accepted -> no ram_we, state RUN, cpu_stall=0 immediately; subsequent ld_start restarts at address 0.
REQ-032 LOAD_WORDS=256 full session -> last write @8'hFF, ptr wraps to 0, ld_done pulse; ld_start issued during session ignored.
REQ-033 INSTRAM_LOAD_CHECKSUM_EN defined, words 16'hFFFF and 16'h0002 -> ld_sum=16'h0001 after session; new ld_start -> ld_sum=0.
